// File: rtl/pwm_peripheral_if.sv
// Control/output bundle between the SPI register block and the PWM peripheral.
//  en_reg_out_7_0 / en_reg_out_15_8 : per-bit output enable for out[7:0] / out[15:8]
//  en_reg_pwm_7_0 / en_reg_pwm_15_8 : per-bit PWM select (1=PWM, 0=static high)
//  pwm_duty_cycle                   : requested duty, 0x00=0%, 0xFF=100%
//  out                              : 16 user outputs
//  period_start                     : one-clk pulse on the first clk of each PWM period
// master = register block / bench side, slave = peripheral side.
interface pwm_peripheral_if;
    logic [7:0]  en_reg_out_7_0;
    logic [7:0]  en_reg_out_15_8;
    logic [7:0]  en_reg_pwm_7_0;
    logic [7:0]  en_reg_pwm_15_8;
    logic [7:0]  pwm_duty_cycle;
    logic [15:0] out;
    logic        period_start;

    modport master (
        output en_reg_out_7_0,
        output en_reg_out_15_8,
        output en_reg_pwm_7_0,
        output en_reg_pwm_15_8,
        output pwm_duty_cycle,
        input  out,
        input  period_start
    );

    modport slave (
        input  en_reg_out_7_0,
        input  en_reg_out_15_8,
        input  en_reg_pwm_7_0,
        input  en_reg_pwm_15_8,
        input  pwm_duty_cycle,
        output out,
        output period_start
    );
endinterface

// File: rtl/pwm_peripheral.sv
// Drives 16 user outputs from the SPI control registers. Each output is forced low,
// held static high, or follows one shared, phase-aligned PWM waveform. The duty value
// is shadowed at the period boundary so a mid-period write never produces a runt pulse.
// Ports:
//  clk    : system clock
//  rst_n  : asynchronous active-low reset
//  bus    : pwm_peripheral_if.slave (enables, duty in; out, period_start out)
// Parameter:
//  CLK_DIV : clk cycles per PWM count (>=1); period = 256*CLK_DIV clk cycles
module pwm_peripheral #(
    parameter int unsigned CLK_DIV = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    pwm_peripheral_if.slave  bus
);

    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned OUT_W   = 16;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_cnt;
    logic [CNT_W-1:0] pwm_cnt;
    logic [CNT_W-1:0] duty_q;

    logic             tick_c;
    logic             wrap_c;
    logic             lvl_c;
    logic [OUT_W-1:0] en_out_c;
    logic [OUT_W-1:0] en_pwm_c;
    logic [OUT_W-1:0] out_d_c;

    // Prescaler tick and end-of-period detect.
    assign tick_c = (div_cnt == DIV_MAX);
    assign wrap_c = tick_c && (pwm_cnt == CNT_W'(8'hFF));

    // 0xFF is special-cased so full scale means a true 100% (256 of 256 counts).
    assign lvl_c = (duty_q == CNT_W'(8'hFF)) ? 1'b1 : (pwm_cnt < duty_q);

    assign en_out_c = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
    assign en_pwm_c = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};

    // Per-bit output select; PWM select only matters when the output is enabled.
    always_comb begin
        out_d_c = '0;
        for (int i = 0; i < int'(OUT_W); i++) begin
            if (en_out_c[i]) begin
                out_d_c[i] = en_pwm_c[i] ? lvl_c : 1'b1;
            end
        end
    end

    // Counters, duty shadow and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt          <= '0;
            pwm_cnt          <= '0;
            duty_q           <= '0;
            bus.out          <= '0;
            bus.period_start <= 1'b0;
        end else begin
            div_cnt <= tick_c ? '0 : div_cnt + DIV_W'(1);
            if (tick_c) begin
                pwm_cnt <= pwm_cnt + CNT_W'(1);
            end
            // Sampled only at the boundary: the last write in a period wins.
            if (wrap_c) begin
                duty_q <= bus.pwm_duty_cycle;
            end
            bus.out          <= out_d_c;
            bus.period_start <= wrap_c;
        end
    end

endmodule

// File: tb/tb_pwm_peripheral.sv
// Self-checking bench for pwm_peripheral. A cycle-indexed reference predicts out and
// period_start from the elapsed clk count since reset release and the stimulus, pushes
// the prediction per clk, and each scenario task pops and compares it on the falling edge.
module tb_pwm_peripheral;

    localparam int CLK_DIV = 13;
    localparam int PERIOD  = 256 * CLK_DIV;

    typedef struct packed {
        logic [15:0] out;
        logic        ps;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int checks = 0;
    int errors = 0;

    exp_t exp_q[$];

    pwm_peripheral_if bus ();

    pwm_peripheral #(.CLK_DIV(CLK_DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference: n_st = clk edges since reset release; duty shadow taken from the
    // requested duty seen on the last edge of each period.
    int         n_st   = 0;
    logic [7:0] m_duty = 8'h00;
    exp_t       ex_m;

    always @(posedge clk) begin
        int         ph;
        int         cnt;
        logic       lvl;
        logic [15:0] en_o;
        logic [15:0] en_p;
        if (!rst_n) begin
            n_st   = 0;
            m_duty = 8'h00;
        end else begin
            ph   = n_st % PERIOD;
            cnt  = ph / CLK_DIV;
            lvl  = (m_duty == 8'hFF) || (cnt < int'(m_duty));
            en_o = {bus.en_reg_out_15_8, bus.en_reg_out_7_0};
            en_p = {bus.en_reg_pwm_15_8, bus.en_reg_pwm_7_0};
            for (int i = 0; i < 16; i++) begin
                ex_m.out[i] = en_o[i] & (en_p[i] ? lvl : 1'b1);
            end
            ex_m.ps = (ph == PERIOD - 1);
            exp_q.push_back(ex_m);
            if (ph == PERIOD - 1) begin
                m_duty = bus.pwm_duty_cycle;
            end
            n_st++;
        end
    end

    task automatic set_inputs(input logic [15:0] en_out, input logic [15:0] en_pwm,
                              input logic [7:0] duty);
        bus.en_reg_out_7_0  = en_out[7:0];
        bus.en_reg_out_15_8 = en_out[15:8];
        bus.en_reg_pwm_7_0  = en_pwm[7:0];
        bus.en_reg_pwm_15_8 = en_pwm[15:8];
        bus.pwm_duty_cycle  = duty;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_inputs(16'hFFFF, 16'h0000, 8'h00);
        repeat (3) @(negedge clk);
        checks++;
        if (bus.out !== 16'h0000) begin
            errors++; $display("FAIL reset_out got=%h exp=%h", bus.out, 16'h0000);
        end
        checks++;
        if (bus.period_start !== 1'b0) begin
            errors++; $display("FAIL reset_ps got=%b exp=0", bus.period_start);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_static_high();
        exp_t ex;
        int   last_ps = -1;
        int   n_ps = 0;
        for (int c = 0; c < 2 * PERIOD + 16; c++) begin
            @(negedge clk);
            checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL sb_static queue_size=0 exp>0");
            end else begin
                ex = exp_q.pop_front();
                if ({bus.out, bus.period_start} !== {ex.out, ex.ps}) begin
                    errors++; $display("FAIL sb_static got out=%h ps=%b exp out=%h ps=%b",
                                       bus.out, bus.period_start, ex.out, ex.ps);
                end
            end
            if (c == 1) begin
                checks++;
                if (bus.out !== 16'hFFFF) begin
                    errors++; $display("FAIL static_out got=%h exp=ffff", bus.out);
                end
            end
            if (bus.period_start === 1'b1) begin
                checks++;
                if (last_ps < 0 ? (c != PERIOD - 1) : (c - last_ps != PERIOD)) begin
                    errors++; $display("FAIL static_ps_spacing got_at=%0d prev=%0d exp_gap=%0d",
                                       c, last_ps, PERIOD);
                end
                last_ps = c;
                n_ps++;
            end
        end
        checks++;
        if (n_ps != 2) begin
            errors++; $display("FAIL static_ps_count got=%0d exp=2", n_ps);
        end
    endtask

    task automatic test_pwm_half();
        exp_t ex;
        bit   found = 0;
        int   highs = 0;
        int   rises = 0;
        logic prev;
        set_inputs(16'h0001, 16'h0001, 8'h80);
        for (int c = 0; c < PERIOD + 2 && !found; c++) begin
            @(negedge clk);
            checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL sb_half_wait queue_size=0 exp>0");
            end else begin
                ex = exp_q.pop_front();
                if ({bus.out, bus.period_start} !== {ex.out, ex.ps}) begin
                    errors++; $display("FAIL sb_half_wait got out=%h ps=%b exp out=%h ps=%b",
                                       bus.out, bus.period_start, ex.out, ex.ps);
                end
            end
            if (bus.period_start === 1'b1) found = 1;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL half_wait_ps got=none exp=pulse within %0d", PERIOD + 2);
        end
        prev = bus.out[0];
        for (int k = 1; k <= PERIOD; k++) begin
            @(negedge clk);
            checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL sb_half queue_size=0 exp>0");
            end else begin
                ex = exp_q.pop_front();
                if ({bus.out, bus.period_start} !== {ex.out, ex.ps}) begin
                    errors++; $display("FAIL sb_half got out=%h ps=%b exp out=%h ps=%b",
                                       bus.out, bus.period_start, ex.out, ex.ps);
                end
            end
            if (bus.out[0] === 1'b1) highs++;
            if (bus.out[0] === 1'b1 && prev === 1'b0) rises++;
            prev = bus.out[0];
        end
        checks++;
        if (highs != PERIOD / 2) begin
            errors++; $display("FAIL half_high_time got=%0d exp=%0d", highs, PERIOD / 2);
        end
        checks++;
        if (rises != 1) begin
            errors++; $display("FAIL half_rises got=%0d exp=1", rises);
        end
    endtask

    task automatic test_duty_extremes();
        exp_t ex;
        for (int pass = 0; pass < 2; pass++) begin
            bit   found = 0;
            int   wrong = 0;
            logic lvl_exp = (pass == 1);
            set_inputs(16'h0001, 16'h0001, (pass == 0) ? 8'h00 : 8'hFF);
            for (int c = 0; c < PERIOD + 2 && !found; c++) begin
                @(negedge clk);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL sb_ext_wait queue_size=0 exp>0");
                end else begin
                    ex = exp_q.pop_front();
                    if ({bus.out, bus.period_start} !== {ex.out, ex.ps}) begin
                        errors++; $display("FAIL sb_ext_wait got out=%h ps=%b exp out=%h ps=%b",
                                           bus.out, bus.period_start, ex.out, ex.ps);
                    end
                end
                if (bus.period_start === 1'b1) found = 1;
            end
            checks++;
            if (!found) begin
                errors++; $display("FAIL ext_wait_ps pass=%0d got=none exp=pulse", pass);
            end
            // Window spans the following boundary to catch any pulse at the wrap.
            for (int k = 1; k <= PERIOD + 2; k++) begin
                @(negedge clk);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL sb_ext queue_size=0 exp>0");
                end else begin
                    ex = exp_q.pop_front();
                    if ({bus.out, bus.period_start} !== {ex.out, ex.ps}) begin
                        errors++; $display("FAIL sb_ext got out=%h ps=%b exp out=%h ps=%b",
                                           bus.out, bus.period_start, ex.out, ex.ps);
                    end
                end
                if (bus.out[0] !== lvl_exp) wrong++;
            end
            checks++;
            if (wrong != 0) begin
                errors++; $display("FAIL ext_constant pass=%0d got=%0d_off_cycles exp=0 level=%b",
                                   pass, wrong, lvl_exp);
            end
        end
    endtask

    task automatic test_mid_period_write();
        exp_t ex;
        bit   found = 0;
        int   h1 = 0;
        int   h2 = 0;
        set_inputs(16'h0001, 16'h0001, 8'h40);
        for (int c = 0; c < PERIOD + 2 && !found; c++) begin
            @(negedge clk);
            checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL sb_mid_wait queue_size=0 exp>0");
            end else begin
                ex = exp_q.pop_front();
                if ({bus.out, bus.period_start} !== {ex.out, ex.ps}) begin
                    errors++; $display("FAIL sb_mid_wait got out=%h ps=%b exp out=%h ps=%b",
                                       bus.out, bus.period_start, ex.out, ex.ps);
                end
            end
            if (bus.period_start === 1'b1) found = 1;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL mid_wait_ps got=none exp=pulse");
        end
        for (int k = 1; k <= 2 * PERIOD; k++) begin
            @(negedge clk);
            checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL sb_mid queue_size=0 exp>0");
            end else begin
                ex = exp_q.pop_front();
                if ({bus.out, bus.period_start} !== {ex.out, ex.ps}) begin
                    errors++; $display("FAIL sb_mid got out=%h ps=%b exp out=%h ps=%b",
                                       bus.out, bus.period_start, ex.out, ex.ps);
                end
            end
            if (bus.out[0] === 1'b1) begin
                if (k <= PERIOD) h1++; else h2++;
            end
            // Two writes in the same period; only the later one may take effect.
            if (k == 100) bus.pwm_duty_cycle = 8'h10;
            if (k == 10 * CLK_DIV) bus.pwm_duty_cycle = 8'hC0;
        end
        checks++;
        if (h1 != 64 * CLK_DIV) begin
            errors++; $display("FAIL mid_cur_period got=%0d exp=%0d", h1, 64 * CLK_DIV);
        end
        checks++;
        if (h2 != 192 * CLK_DIV) begin
            errors++; $display("FAIL mid_next_period got=%0d exp=%0d", h2, 192 * CLK_DIV);
        end
    endtask

    task automatic test_enable_gating();
        exp_t ex;
        set_inputs(16'h00FF, 16'hFF00, 8'h80);
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL sb_gate queue_size=0 exp>0");
            end else begin
                ex = exp_q.pop_front();
                if ({bus.out, bus.period_start} !== {ex.out, ex.ps}) begin
                    errors++; $display("FAIL sb_gate got out=%h ps=%b exp out=%h ps=%b",
                                       bus.out, bus.period_start, ex.out, ex.ps);
                end
            end
            if (c == 1 || c == 399) begin
                checks++;
                if (bus.out !== 16'h00FF) begin
                    errors++; $display("FAIL gate_out cyc=%0d got=%h exp=00ff", c, bus.out);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t ex;
        bit   found = 0;
        int   first_ps = -1;
        int   highs = 0;
        set_inputs(16'h0001, 16'h0001, 8'h80);
        for (int c = 0; c < PERIOD + 2 && !found; c++) begin
            @(negedge clk);
            checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL sb_rst_wait queue_size=0 exp>0");
            end else begin
                ex = exp_q.pop_front();
                if ({bus.out, bus.period_start} !== {ex.out, ex.ps}) begin
                    errors++; $display("FAIL sb_rst_wait got out=%h ps=%b exp out=%h ps=%b",
                                       bus.out, bus.period_start, ex.out, ex.ps);
                end
            end
            if (bus.period_start === 1'b1) found = 1;
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL rst_wait_ps got=none exp=pulse");
        end
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL sb_rst_pre queue_size=0 exp>0");
            end else begin
                ex = exp_q.pop_front();
                if ({bus.out, bus.period_start} !== {ex.out, ex.ps}) begin
                    errors++; $display("FAIL sb_rst_pre got out=%h ps=%b exp out=%h ps=%b",
                                       bus.out, bus.period_start, ex.out, ex.ps);
                end
            end
        end
        checks++;
        if (bus.out[0] !== 1'b1) begin
            errors++; $display("FAIL rst_pre_high got=%b exp=1", bus.out[0]);
        end
        // Assert between clock edges: clearing must not wait for clk.
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        checks++;
        if (bus.out !== 16'h0000 || bus.period_start !== 1'b0) begin
            errors++; $display("FAIL rst_async got out=%h ps=%b exp out=0000 ps=0",
                               bus.out, bus.period_start);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (bus.out !== 16'h0000) begin
            errors++; $display("FAIL rst_hold got=%h exp=0000", bus.out);
        end
        rst_n = 1'b1;
        for (int c = 0; c < PERIOD + 8; c++) begin
            @(negedge clk);
            checks++;
            if (exp_q.size() == 0) begin
                errors++; $display("FAIL sb_rst_post queue_size=0 exp>0");
            end else begin
                ex = exp_q.pop_front();
                if ({bus.out, bus.period_start} !== {ex.out, ex.ps}) begin
                    errors++; $display("FAIL sb_rst_post got out=%h ps=%b exp out=%h ps=%b",
                                       bus.out, bus.period_start, ex.out, ex.ps);
                end
            end
            if (bus.period_start === 1'b1 && first_ps < 0) first_ps = c;
            if (first_ps < 0 && bus.out[0] === 1'b1) highs++;
        end
        checks++;
        if (first_ps != PERIOD - 1) begin
            errors++; $display("FAIL rst_first_ps got=%0d exp=%0d", first_ps, PERIOD - 1);
        end
        checks++;
        if (highs != 0) begin
            errors++; $display("FAIL rst_first_period_low got=%0d exp=0", highs);
        end
    endtask

    initial begin
        test_reset();
        test_static_high();
        test_pwm_half();
        test_duty_extremes();
        test_mid_period_write();
        test_enable_gating();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL sb_leftover got=%0d exp=0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
